// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// default widths/constants.
package if_fetch_unit_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  // FETCH: request outstanding or about to issue for the next instruction.
  // VALID: one fetched instruction parked in the buffer, no request.
  // DRAIN: a request issued before a redirect is still in flight; its
  //        response must be swallowed before fetching the new target.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, talks to a variable-latency
// instruction memory and feeds the IF/ID register, inserting a bubble
// whenever the pipeline advances without an instruction to present.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              PCSrc,
  input  logic [DATA_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [DATA_W-1:0] JumpTarget,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] PCadderResult,
  output logic [DATA_W-1:0] ReadData,
  output logic              IF_ID_Write,
  output logic              IF_Flush,
  output logic [DATA_W-1:0] PC
);

  state_t            r_state, w_state_d;
  logic [DATA_W-1:0] r_pc, w_pc_d;
  logic [DATA_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0] r_buf, w_buf_d;

  logic              w_redirect;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W-1:0] w_pc_inc;
  logic              w_req, w_wr, w_fl;
  logic [DATA_W-1:0] w_read;

  // Jump resolves ahead of a taken branch when both fire together.
  assign w_redirect = Jump | PCSrc;
  assign w_target   = Jump ? JumpTarget : BranchTarget;
  assign w_pc_inc   = r_pc + DATA_W'(PC_INC);

  // State and datapath registers; reset restarts fetch at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_addr  <= w_addr_d;
      r_buf   <= w_buf_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_addr_d  = r_addr;
    w_buf_d   = r_buf;
    w_req     = 1'b1;
    w_read    = imem_rdata;
    w_wr      = 1'b0;
    w_fl      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_redirect) begin
          w_fl   = 1'b1;
          w_pc_d = w_target;
          if (imem_ready) begin
            w_addr_d = w_target;
          end else begin
            // Keep addr stable: the old request is still owed a response.
            w_state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          if (PCWrite) begin
            w_wr     = 1'b1;
            w_pc_d   = w_pc_inc;
            w_addr_d = w_pc_inc;
          end else begin
            w_buf_d   = imem_rdata;
            w_state_d = S_VALID;
          end
        end else begin
          w_fl = PCWrite;
        end
      end
      S_VALID: begin
        w_req  = 1'b0;
        w_read = r_buf;
        w_wr   = PCWrite & ~w_redirect;
        if (w_redirect) begin
          w_fl      = 1'b1;
          w_pc_d    = w_target;
          w_addr_d  = w_target;
          w_state_d = S_FETCH;
        end else if (PCWrite) begin
          w_pc_d    = w_pc_inc;
          w_addr_d  = w_pc_inc;
          w_state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        w_fl = PCWrite | w_redirect;
        if (w_redirect) begin
          w_pc_d = w_target;
        end
        if (imem_ready) begin
          w_addr_d  = w_redirect ? w_target : r_pc;
          w_state_d = S_FETCH;
        end
      end
      default: begin
        w_state_d = S_FETCH;
      end
    endcase
  end

  assign imem_req      = w_req;
  assign imem_addr     = r_addr;
  assign ReadData      = w_read;
  assign PCadderResult = w_pc_inc;
  assign IF_ID_Write   = w_wr & ~rst;
  assign IF_Flush      = w_fl & ~rst;
  assign PC            = r_pc;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the PC, issues requests on a variable-latency instruction-memory port, and buffers one fetched instruction across stalls. It drives PCadderResult, ReadData, IF_ID_Write and IF_Flush, and inserts a bubble (flush) whenever the pipeline advances without a valid instruction. Redirects come from branch/jump resolution in ID; stalls come from the hazard unit via PCWrite.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DATA_W, 32, instruction and address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
PCWrite  in  1  1 = pipeline advances this cycle; 0 = hazard stall
PCSrc  in  1  branch taken in ID
BranchTarget  in  32  branch destination
Jump  in  1  jump in ID; has priority over PCSrc
JumpTarget  in  32  jump destination
imem_req  out  1  memory request valid
imem_addr  out  32  request address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  response valid this cycle (0 or more cycles after request)
imem_rdata  in  32  instruction, valid when imem_ready=1
PCadderResult  out  32  PC+4 of the presented instruction
ReadData  out  32  presented instruction
IF_ID_Write  out  1  IF/ID capture enable
IF_Flush  out  1  zero IF/ID instruction at next edge
PC  out  32  current fetch PC (debug)

Behaviour:
- Registers: pc_q, addr_q, buf_q, state {FETCH, VALID, DRAIN}. Reset: pc_q=RESET_PC, addr_q=RESET_PC, buf_q=0, state=FETCH. Every output is combinational from these registers and the inputs. While rst=1, IF_ID_Write=0 and IF_Flush=0.
- redirect = Jump | PCSrc. target = Jump ? JumpTarget : BranchTarget. A redirect is honoured in every state, regardless of PCWrite.
- imem_req=1 in FETCH and DRAIN, 0 in VALID. imem_addr=addr_q. Exactly one response per request.
- FETCH:
  - imem_ready & ~redirect & PCWrite: bypass. ReadData=imem_rdata, PCadderResult=pc_q+4, IF_ID_Write=1. pc_q and addr_q <= pc_q+4. Stay in FETCH. Throughput is 1 instruction/cycle with zero-latency memory.
  - imem_ready & ~redirect & ~PCWrite: buf_q<=imem_rdata, go to VALID. Outputs are 0 for both enables.
  - ~imem_ready & ~redirect: stay in FETCH. IF_Flush=PCWrite (bubble). IF_ID_Write=0.
  - redirect: IF_Flush=1, IF_ID_Write=0, pc_q<=target.
    - With imem_ready: discard the response, addr_q<=target, stay in FETCH.
    - Without imem_ready: go to DRAIN. addr_q is held so the outstanding request stays stable.
- VALID: ReadData=buf_q, PCadderResult=pc_q+4, IF_ID_Write=PCWrite & ~redirect.
  - redirect: IF_Flush=1, pc_q and addr_q<=target, go to FETCH.
  - PCWrite: pc_q and addr_q<=pc_q+4, go to FETCH.
  - Otherwise hold.
- DRAIN: wait for the stale response, then discard it. IF_Flush=PCWrite | redirect. IF_ID_Write=0.
  - imem_ready: addr_q<=pc_q (or target if a new redirect arrives), go to FETCH.
  - A new redirect in DRAIN updates pc_q only.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Simultaneous Jump & PCSrc: Jump wins.
- rst mid-transaction: go straight to FETCH at RESET_PC. A late response to the aborted request is the memory's responsibility; the memory is reset on the same rst.

Decomposition:
- Shared package: state encoding (FETCH, VALID, DRAIN), DATA_W, RESET_PC default, PC_INC=4.
- No sub-module required. The PC adder stays inline.

Test Plan:
- imem_ready tied 1, PCWrite=1 after reset: PCadderResult 4, 8, 12 on consecutive cycles. IF_ID_Write=1 every cycle. IF_Flush=0.
- imem_ready with 2-cycle latency, PCWrite=1: IF_Flush=1 for 2 cycles, then IF_ID_Write=1 with ReadData=rdata. PC advances by 4 per instruction.
- Response arrives while PCWrite=0 for 3 cycles: state is VALID. ReadData holds, IF_ID_Write=0 and IF_Flush=0 for 3 cycles. IF_ID_Write=1 on the 4th cycle. imem_req=0 while VALID.
- PCSrc=1, BranchTarget=32'h40, in VALID: IF_Flush=1 that cycle. The next imem_addr=32'h40 and the next presented PCadderResult=32'h44.
- Jump=1 (JumpTarget 32'h100) while a request to 32'h8 is outstanding: DRAIN holds imem_addr=32'h8 until imem_ready. The stale rdata is never presented. The next request is to 32'h100.
- Jump=1 and PCSrc=1 in the same cycle with targets 32'h100 and 32'h40: the next fetch is from 32'h100. Then pc_q=32'hFFFF_FFFC with imem_ready=1 and PCWrite=1: the fetch after that is from 32'h0.
